if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 257 +++++++++++++++++++++++++
 tb/tb_if_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with an IF/ID pipeline register.
//
// Fetches one instruction word at a time from an instruction memory over a
// request/grant + rvalid handshake (at most one request outstanding), tracks
// the sequential fetch PC, accepts branch/jump redirects from the branch unit
// and presents fetched instructions to ID through the IF/ID register.
//
// Configuration macro: DELAY_SLOT_EN
//   defined   : the instruction in flight (or held) when a redirect arrives is
//               delivered normally as the branch delay slot.
//   undefined : that instruction is squashed; the next valid instruction comes
//               from the redirect target.
//
// Parameters
//   RESET_PC     first fetch address after reset
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   redir_valid  redirect request from the branch unit
//   redir_pc     redirect target (low 2 bits ignored)
//   stall        ID back-pressure; IF/ID held while 1, no new request issued
//   imem_req     fetch request valid (registered)
//   imem_addr    word-aligned fetch address (registered)
//   imem_gnt     memory accepted the request
//   imem_rvalid  read data valid
//   imem_rdata   instruction word
//   if_valid     IF/ID register holds a valid instruction
//   if_pc        address of the instruction in IF/ID
//   if_instr     instruction word in IF/ID
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Clear the byte-offset bits of an address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

    // Architectural state
    state_t      state_r;
    logic [31:0] fetch_pc_r;      // next sequential fetch address
    logic        pend_valid_r;    // a redirect is waiting for the next request
    logic [31:0] pend_pc_r;
    logic [31:0] req_pc_r;        // address of the granted, outstanding request
    logic [31:0] hold_pc_r;       // response captured while ID was stalled
    logic [31:0] hold_instr_r;
    logic        squash_r;        // outstanding response must be dropped

    // Registered outputs
    logic        imem_req_r;
    logic [31:0] imem_addr_r;
    logic        if_valid_r;
    logic [31:0] if_pc_r;
    logic [31:0] if_instr_r;

    // Next-state decode
    state_t      state_n_s;
    logic        squash_n_s;
    logic        want_req_s;      // FSM is in (or entering) REQ with nothing presented
    logic        issue_s;         // a new request is presented this edge
    logic        grant_s;         // presented request accepted this edge
    logic        capture_s;       // response goes into the hold buffer
    logic        deliver_s;       // IF/ID gets a new instruction this edge
    logic [31:0] deliver_pc_s;
    logic [31:0] deliver_instr_s;
    logic        redir_kill_s;    // a redirect this cycle squashes the in-flight word
    logic        kill_s;
    logic [31:0] redir_addr_s;
    logic        pend_any_s;
    logic [31:0] pend_addr_s;
    logic [31:0] issue_addr_s;

    assign imem_req  = imem_req_r;
    assign imem_addr = imem_addr_r;
    assign if_valid  = if_valid_r;
    assign if_pc     = if_pc_r;
    assign if_instr  = if_instr_r;

`ifdef DELAY_SLOT_EN
    assign redir_kill_s = 1'b0;
`else
    assign redir_kill_s = redir_valid;
`endif

    // Redirect merge: a redirect arriving in the same cycle as an issue is
    // used directly, so the newest redirect always wins.
    assign redir_addr_s = word_align(redir_pc);
    assign pend_any_s   = pend_valid_r | redir_valid;
    assign pend_addr_s  = redir_valid ? redir_addr_s : pend_pc_r;
    assign issue_addr_s = pend_any_s ? pend_addr_s : word_align(fetch_pc_r);
    assign kill_s       = squash_r | redir_kill_s;

    // FSM next-state and datapath control decode.
    always_comb begin
        state_n_s       = state_r;
        squash_n_s      = squash_r;
        want_req_s      = 1'b0;
        grant_s         = 1'b0;
        capture_s       = 1'b0;
        deliver_s       = 1'b0;
        deliver_pc_s    = 32'h0000_0000;
        deliver_instr_s = 32'h0000_0000;

        case (state_r)
            IDLE: begin
                state_n_s  = REQ;
                want_req_s = 1'b1;
            end

            REQ: begin
                if (imem_req_r) begin
                    // A presented request is held stable until granted, even
                    // if ID stalls; a redirect now marks its word for squash.
                    squash_n_s = squash_r | redir_kill_s;
                    if (imem_gnt) begin
                        grant_s   = 1'b1;
                        state_n_s = WAIT;
                    end else begin
                        state_n_s = REQ;
                    end
                end else begin
                    want_req_s = 1'b1;
                end
            end

            WAIT: begin
                if (imem_rvalid) begin
                    if (kill_s) begin
                        squash_n_s = 1'b0;
                        state_n_s  = REQ;
                        want_req_s = 1'b1;
                    end else if (!stall) begin
                        deliver_s       = 1'b1;
                        deliver_pc_s    = req_pc_r;
                        deliver_instr_s = imem_rdata;
                        state_n_s       = REQ;
                        want_req_s      = 1'b1;
                    end else begin
                        capture_s = 1'b1;
                        state_n_s = HOLD;
                    end
                end else begin
                    squash_n_s = squash_r | redir_kill_s;
                end
            end

            HOLD: begin
                if (kill_s) begin
                    // Held word is dropped; IF/ID is untouched so a stalled
                    // ID still sees its current instruction.
                    squash_n_s = 1'b0;
                    state_n_s  = REQ;
                    want_req_s = 1'b1;
                end else if (!stall) begin
                    deliver_s       = 1'b1;
                    deliver_pc_s    = hold_pc_r;
                    deliver_instr_s = hold_instr_r;
                    state_n_s       = REQ;
                    want_req_s      = 1'b1;
                end else begin
                    state_n_s = HOLD;
                end
            end

            default: begin
                state_n_s  = IDLE;
                squash_n_s = 1'b0;
            end
        endcase

        issue_s = want_req_s & ~stall;
    end

    // State, pending redirect, hold buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            fetch_pc_r   <= word_align(RESET_PC);
            pend_valid_r <= 1'b0;
            pend_pc_r    <= 32'h0000_0000;
            req_pc_r     <= 32'h0000_0000;
            hold_pc_r    <= 32'h0000_0000;
            hold_instr_r <= 32'h0000_0000;
            squash_r     <= 1'b0;
            imem_req_r   <= 1'b0;
            imem_addr_r  <= 32'h0000_0000;
            if_valid_r   <= 1'b0;
            if_pc_r      <= 32'h0000_0000;
            if_instr_r   <= 32'h0000_0000;
        end else begin
            state_r  <= state_n_s;
            squash_r <= squash_n_s;

            if (issue_s) begin
                imem_req_r  <= 1'b1;
                imem_addr_r <= issue_addr_s;
            end else if (grant_s) begin
                imem_req_r  <= 1'b0;
            end

            // Issuing consumes the pending redirect (including one arriving
            // this very cycle); otherwise the newest redirect is recorded.
            if (issue_s) begin
                pend_valid_r <= 1'b0;
            end else if (redir_valid) begin
                pend_valid_r <= 1'b1;
                pend_pc_r    <= redir_addr_s;
            end

            // Sequential PC follows the granted address, wrapping mod 2^32.
            if (grant_s) begin
                req_pc_r   <= imem_addr_r;
                fetch_pc_r <= imem_addr_r + 32'd4;
            end

            if (capture_s) begin
                hold_pc_r    <= req_pc_r;
                hold_instr_r <= imem_rdata;
            end

            if (deliver_s) begin
                if_valid_r <= 1'b1;
                if_pc_r    <= deliver_pc_s;
                if_instr_r <= deliver_instr_s;
            end else if (!stall) begin
                if_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- directed self-checking bench for if_stage.
// Each scenario task drives the memory handshake by hand at the falling clock
// edge and compares DUT outputs against hand-computed constants.
// Honours DELAY_SLOT_EN for the redirect scenarios.
// -----------------------------------------------------------------------------
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int n_checks = 0;
    int n_fail   = 0;

    if_stage #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Wait (bounded) at falling edges until a request is presented.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (imem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Grant the presented request, return data next cycle; ends at the
    // falling edge where the delivered instruction is visible.
    task automatic serve(input logic [31:0] data, output logic [31:0] addr, output bit ok);
        wait_req(ok);
        addr = imem_addr;
        if (ok) begin
            imem_gnt = 1'b1;
            @(negedge clk);
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b1;
            imem_rdata  = data;
            @(negedge clk);
            imem_rvalid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_checks++; if (imem_addr !== 32'h0000_0000) begin n_fail++; $display("FAIL rst_addr: got %h want 00000000", imem_addr); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid); end
        n_checks++; if (if_pc !== 32'h0000_0000) begin n_fail++; $display("FAIL rst_pc: got %h want 00000000", if_pc); end
        n_checks++; if (if_instr !== 32'h0000_0000) begin n_fail++; $display("FAIL rst_instr: got %h want 00000000", if_instr); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr [3];
        logic [31:0] data [3];
        logic [31:0] a;
        bit ok;
        exp_addr[0] = 32'hBFC0_0000; exp_addr[1] = 32'hBFC0_0004; exp_addr[2] = 32'hBFC0_0008;
        data[0] = 32'h1111_0001; data[1] = 32'h2222_0002; data[2] = 32'h3333_0003;
        for (int i = 0; i < 3; i++) begin
            serve(data[i], a, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL seq_timeout%0d: no request seen", i); end
            n_checks++; if (a !== exp_addr[i]) begin n_fail++; $display("FAIL seq_addr%0d: got %h want %h", i, a, exp_addr[i]); end
            n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d: got %b want 1", i, if_valid); end
            n_checks++; if (if_pc !== exp_addr[i]) begin n_fail++; $display("FAIL seq_pc%0d: got %h want %h", i, if_pc, exp_addr[i]); end
            n_checks++; if (if_instr !== data[i]) begin n_fail++; $display("FAIL seq_instr%0d: got %h want %h", i, if_instr, data[i]); end
        end
    endtask

    task automatic test_stall();
        bit ok;
        wait_req(ok);
        n_checks++; if (!ok || imem_addr !== 32'hBFC0_000C) begin n_fail++; $display("FAIL stall_addr1: got %h want bfc0000c", imem_addr); end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hD1D1_0001;
        @(negedge clk);
        imem_rvalid = 1'b0;
        n_checks++; if (if_valid !== 1'b1 || if_instr !== 32'hD1D1_0001) begin n_fail++; $display("FAIL stall_pre: got %b/%h want 1/d1d10001", if_valid, if_instr); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0010) begin n_fail++; $display("FAIL stall_addr2: got %b/%h want 1/bfc00010", imem_req, imem_addr); end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hD2D2_0002; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            n_checks++; if (if_instr !== 32'hD1D1_0001 || if_pc !== 32'hBFC0_000C || if_valid !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d: got %b/%h/%h want 0/bfc0000c/d1d10001", i, if_valid, if_pc, if_instr); end
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_noreq%0d: got %b want 0", i, imem_req); end
        end
        stall = 1'b0;
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'hBFC0_0010 || if_instr !== 32'hD2D2_0002) begin n_fail++; $display("FAIL stall_release: got %b/%h/%h want 1/bfc00010/d2d20002", if_valid, if_pc, if_instr); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0014) begin n_fail++; $display("FAIL stall_next: got %b/%h want 1/bfc00014", imem_req, imem_addr); end
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stall_consume: got %b want 0", if_valid); end
    endtask

    task automatic test_redirect_stall();
        logic [31:0] a;
        bit ok;
        @(negedge clk);
        rst = 1'b1; stall = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rds_noreq0: got %b want 0", imem_req); end
        redir_valid = 1'b1; redir_pc = 32'h0000_0100;
        @(negedge clk);
        redir_pc = 32'h0000_0200;
        @(negedge clk);
        redir_valid = 1'b0;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rds_noreq1: got %b want 0", imem_req); end
        stall = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin n_fail++; $display("FAIL rds_addr: got %b/%h want 1/00000200", imem_req, imem_addr); end
        serve(32'hCAFE_0200, a, ok);
        n_checks++; if (!ok || if_valid !== 1'b1 || if_pc !== 32'h0000_0200 || if_instr !== 32'hCAFE_0200) begin n_fail++; $display("FAIL rds_deliver: got %b/%h/%h want 1/00000200/cafe0200", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_redirect_wait();
        logic [31:0] a;
        bit ok;
        wait_req(ok);
        n_checks++; if (!ok || imem_addr !== 32'h0000_0204) begin n_fail++; $display("FAIL rdw_addr0: got %h want 00000204", imem_addr); end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; redir_valid = 1'b1; redir_pc = 32'h0040_0103;
        @(negedge clk);
        redir_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hABCD_0204;
        @(negedge clk);
        imem_rvalid = 1'b0;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin n_fail++; $display("FAIL rdw_target: got %b/%h want 1/00400100", imem_req, imem_addr); end
`ifdef DELAY_SLOT_EN
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_0204 || if_instr !== 32'hABCD_0204) begin n_fail++; $display("FAIL rdw_slot: got %b/%h/%h want 1/00000204/abcd0204", if_valid, if_pc, if_instr); end
`else
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_squash: got %b want 0", if_valid); end
`endif
        serve(32'h1234_5678, a, ok);
        n_checks++; if (!ok || a !== 32'h0040_0100) begin n_fail++; $display("FAIL rdw_served: got %h want 00400100", a); end
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0100 || if_instr !== 32'h1234_5678) begin n_fail++; $display("FAIL rdw_deliver: got %b/%h/%h want 1/00400100/12345678", if_valid, if_pc, if_instr); end
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0104) begin n_fail++; $display("FAIL rdw_seq: got %b/%h want 1/00400104", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_hold();
        logic [31:0] a;
        bit ok;
        wait_req(ok);
        n_checks++; if (!ok || imem_addr !== 32'h0040_0104) begin n_fail++; $display("FAIL rdh_addr0: got %h want 00400104", imem_addr); end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5555_0104; stall = 1'b1;
        @(negedge clk);
        imem_rvalid = 1'b0; redir_valid = 1'b1; redir_pc = 32'h0000_1002;
        @(negedge clk);
        redir_valid = 1'b0;
        n_checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL rdh_stalled: got %b/%b want 0/0", imem_req, if_valid); end
        stall = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL rdh_target: got %b/%h want 1/00001000", imem_req, imem_addr); end
`ifdef DELAY_SLOT_EN
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0104 || if_instr !== 32'h5555_0104) begin n_fail++; $display("FAIL rdh_slot: got %b/%h/%h want 1/00400104/55550104", if_valid, if_pc, if_instr); end
`else
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rdh_squash: got %b want 0", if_valid); end
`endif
        serve(32'h6666_1000, a, ok);
        n_checks++; if (!ok || if_valid !== 1'b1 || if_pc !== 32'h0000_1000 || if_instr !== 32'h6666_1000) begin n_fail++; $display("FAIL rdh_deliver: got %b/%h/%h want 1/00001000/66661000", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        bit ok;
        wait_req(ok);
        n_checks++; if (!ok || imem_addr !== 32'h0000_1004) begin n_fail++; $display("FAIL wrap_addr0: got %h want 00001004", imem_addr); end
        // redirect coincides with the grant: granted address must not change
        imem_gnt = 1'b1; redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        imem_gnt = 1'b0; redir_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h7777_1004;
        @(negedge clk);
        imem_rvalid = 1'b0;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_target: got %b/%h want 1/fffffffc", imem_req, imem_addr); end
`ifdef DELAY_SLOT_EN
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_1004) begin n_fail++; $display("FAIL wrap_gntaddr: got %b/%h want 1/00001004", if_valid, if_pc); end
`else
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_squash: got %b want 0", if_valid); end
`endif
        serve(32'h8888_FFFC, a, ok);
        n_checks++; if (!ok || if_pc !== 32'hFFFF_FFFC || if_instr !== 32'h8888_FFFC) begin n_fail++; $display("FAIL wrap_top: got %h/%h want fffffffc/8888fffc", if_pc, if_instr); end
        serve(32'h9999_0000, a, ok);
        n_checks++; if (!ok || a !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_zero: got %h want 00000000", a); end
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_0000 || if_instr !== 32'h9999_0000) begin n_fail++; $display("FAIL wrap_deliver: got %b/%h/%h want 1/00000000/99990000", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_req(ok);
        n_checks++; if (!ok || imem_addr !== 32'h0000_0004) begin n_fail++; $display("FAIL rmid_addr0: got %h want 00000004", imem_addr); end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0000_0000 || if_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_rst: got %b/%h/%b want 0/00000000/0", imem_req, imem_addr, if_valid); end
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale0: got %b want 0", if_valid); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL rmid_first: got %b/%h want 1/bfc00000", imem_req, imem_addr); end
        @(negedge clk);
        imem_rvalid = 1'b0;
        n_checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0000_0000) begin n_fail++; $display("FAIL rmid_stale1: got %b/%h want 0/00000000", if_valid, if_instr); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL rmid_held: got %b/%h want 1/bfc00000", imem_req, imem_addr); end
    endtask

    initial begin
        rst = 1'b1; redir_valid = 1'b0; redir_pc = 32'h0000_0000; stall = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0000_0000;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
